// File: rtl/z80_bus_pkg.sv
// Shared types and constants for the Z80 bus-cycle front end.
package z80_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_QUALIFY,
    ST_ACTIVE,
    ST_RELEASE
  } bus_state_t;

  localparam logic KIND_READ  = 1'b1;
  localparam logic KIND_WRITE = 1'b0;

  localparam int SYNC_STAGES_DEFAULT = 2;
  localparam int QUAL_CYCLES_DEFAULT = 2;
  localparam int HOLD_CYCLES_DEFAULT = 1;

  // Map a decoded read request onto the stored cycle kind.
  function automatic logic kind_of(input logic is_read);
    return is_read ? KIND_READ : KIND_WRITE;
  endfunction

endpackage

// File: rtl/z80_bus_cycle_sync.sv
// N-stage single-bit synchroniser; every stage resets to 1 so an idle
// (active-low) bus strobe is seen as inactive straight out of reset.
module bus_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the raw pin through the flop chain; stage 0 takes the async input.
  always_ff @(posedge clk) begin
    if (!rst_n) chain <= '1;
    else        chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/z80_bus_cycle.sv
// Z80 bus front end: synchronises and qualifies the control strobes, then
// presents a latched address, a phi2 memory-cycle strobe and rwbar to the
// enable-table lookup stage. Refresh and illegal strobe mixes never yield phi2.
module z80_bus_cycle
  import z80_bus_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter int QUAL_CYCLES = QUAL_CYCLES_DEFAULT,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
  input  logic        fpga_clk,
  input  logic        rst_n,
  input  logic [15:0] z80_addr,
  input  logic        z80_mreq_n,
  input  logic        z80_rd_n,
  input  logic        z80_wr_n,
  input  logic        z80_rfsh_n,
  output logic [15:0] address,
  output logic        phi2,
  output logic        rwbar,
  output logic        cycle_start,
  output logic        protocol_err
);

  localparam int QW = $clog2(QUAL_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [QW-1:0] QUAL_MAX  = QW'(QUAL_CYCLES);
  localparam logic [QW-1:0] QUAL_LAST = QW'(QUAL_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  logic s_mreq, s_rd, s_wr, s_rfsh;

  bus_sync #(.STAGES(SYNC_STAGES)) u_sync_mreq (
    .clk(fpga_clk), .rst_n(rst_n), .d(z80_mreq_n), .q(s_mreq));
  bus_sync #(.STAGES(SYNC_STAGES)) u_sync_rd (
    .clk(fpga_clk), .rst_n(rst_n), .d(z80_rd_n), .q(s_rd));
  bus_sync #(.STAGES(SYNC_STAGES)) u_sync_wr (
    .clk(fpga_clk), .rst_n(rst_n), .d(z80_wr_n), .q(s_wr));
  bus_sync #(.STAGES(SYNC_STAGES)) u_sync_rfsh (
    .clk(fpga_clk), .rst_n(rst_n), .d(z80_rfsh_n), .q(s_rfsh));

  bus_state_t      state;
  logic            kind;
  logic [QW-1:0]   qual_cnt;
  logic [HW-1:0]   hold_cnt;
  logic            err_done;

  logic req_rd, req_wr, req_any, both_low, same_req, enter_active, err_fire;

  // Decode the synchronised strobes; err_done keeps one illegal episode to one pulse.
  always_comb begin
    req_rd       = !s_mreq && s_rfsh && !s_rd && s_wr;
    req_wr       = !s_mreq && s_rfsh && s_rd && !s_wr;
    req_any      = req_rd || req_wr;
    both_low     = !s_mreq && !s_rd && !s_wr;
    same_req     = (kind == KIND_READ) ? req_rd : req_wr;
    enter_active = ((state == ST_IDLE) && req_any && (QUAL_CYCLES == 1)) ||
                   ((state == ST_QUALIFY) && same_req && (qual_cnt == QUAL_LAST));
    err_fire     = both_low && !err_done &&
                   ((state == ST_IDLE) || (state == ST_ACTIVE));
  end

  // Cycle state machine with all downstream outputs registered.
  always_ff @(posedge fpga_clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      kind         <= KIND_READ;
      qual_cnt     <= '0;
      hold_cnt     <= '0;
      err_done     <= 1'b0;
      address      <= '0;
      phi2         <= 1'b0;
      rwbar        <= 1'b1;
      cycle_start  <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      cycle_start  <= 1'b0;
      protocol_err <= err_fire;
      if (err_fire)       err_done <= 1'b1;
      else if (!both_low) err_done <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          if (req_any) begin
            kind     <= kind_of(req_rd);
            qual_cnt <= QW'(1);
            state    <= (QUAL_CYCLES == 1) ? ST_ACTIVE : ST_QUALIFY;
          end
        end
        ST_QUALIFY: begin
          if (same_req) begin
            if (qual_cnt != QUAL_MAX) qual_cnt <= qual_cnt + QW'(1);
            if (qual_cnt == QUAL_LAST) state <= ST_ACTIVE;
          end else begin
            qual_cnt <= '0;
            state    <= ST_IDLE;
          end
        end
        ST_ACTIVE: begin
          if (!same_req) begin
            phi2     <= 1'b0;
            hold_cnt <= '0;
            state    <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (hold_cnt == HOLD_LAST) begin
            rwbar    <= 1'b1;
            hold_cnt <= '0;
            qual_cnt <= '0;
            state    <= ST_IDLE;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (enter_active) begin
        address     <= z80_addr;
        rwbar       <= req_rd;
        phi2        <= 1'b1;
        cycle_start <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_z80_bus_cycle.sv
// Directed bench for z80_bus_cycle: a scoreboard queue holds the expected
// phi2 cycles, a negedge monitor pops and compares them, and the main
// sequence checks latency, hold behaviour and the reject cases.
module tb_z80_bus_cycle;

  localparam int SYNC = 2;
  localparam int QUAL = 2;
  localparam int HOLD = 1;
  localparam int RISE = SYNC + QUAL;

  typedef struct {
    logic [15:0] addr;
    logic        rw;
    int          width;
  } txn_t;

  logic        fpga_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] z80_addr = 16'h0000;
  logic        z80_mreq_n = 1'b1;
  logic        z80_rd_n = 1'b1;
  logic        z80_wr_n = 1'b1;
  logic        z80_rfsh_n = 1'b1;
  logic [15:0] address;
  logic        phi2, rwbar, cycle_start, protocol_err;

  int   checks = 0;
  int   errors = 0;
  txn_t exp_q[$];

  z80_bus_cycle #(
    .SYNC_STAGES(SYNC), .QUAL_CYCLES(QUAL), .HOLD_CYCLES(HOLD)
  ) dut (
    .fpga_clk(fpga_clk), .rst_n(rst_n), .z80_addr(z80_addr),
    .z80_mreq_n(z80_mreq_n), .z80_rd_n(z80_rd_n), .z80_wr_n(z80_wr_n),
    .z80_rfsh_n(z80_rfsh_n), .address(address), .phi2(phi2), .rwbar(rwbar),
    .cycle_start(cycle_start), .protocol_err(protocol_err)
  );

  always #5 fpga_clk = ~fpga_clk;

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the active edge.
  task automatic step();
    @(posedge fpga_clk);
    #2;
  endtask

  task automatic apply_stimulus(input logic [15:0] a, input logic mreq,
                                input logic rd, input logic wr, input logic rfsh);
    z80_addr   = a;
    z80_mreq_n = mreq;
    z80_rd_n   = rd;
    z80_wr_n   = wr;
    z80_rfsh_n = rfsh;
  endtask

  task automatic bus_idle();
    apply_stimulus(z80_addr, 1'b1, 1'b1, 1'b1, 1'b1);
  endtask

  // One memory cycle with the strobes low for n clocks. phi2 rises SYNC+QUAL
  // edges after assertion but falls only SYNC+1 edges after release, so it is
  // high for n-QUAL+1 cycles.
  task automatic run_cycle(input logic [15:0] a, input logic is_read, input int n);
    txn_t t;
    t.addr  = a;
    t.rw    = is_read;
    t.width = n - QUAL + 1;
    exp_q.push_back(t);
    apply_stimulus(a, 1'b0, !is_read, is_read, 1'b1);
    for (int k = 1; k <= n; k++) begin
      step();
      check_output("phi2_assert", phi2, (k >= RISE));
      if (k == RISE) begin
        check_output("cycle_start", cycle_start, 1);
        check_output("address", address, a);
        check_output("rwbar", rwbar, is_read);
      end
    end
    bus_idle();
    for (int j = 1; j <= SYNC + HOLD + 2; j++) begin
      step();
      check_output("phi2_release", phi2, (j <= SYNC));
      if (j == SYNC + 1) begin
        check_output("addr_hold", address, a);
        check_output("rw_hold", rwbar, is_read);
      end
      if (j == SYNC + 1 + HOLD) check_output("rw_restore", rwbar, 1);
    end
  endtask

  logic        prev_phi2 = 1'b0;
  logic        in_cycle = 1'b0;
  int          width = 0;
  logic [15:0] got_addr;
  logic        got_rw;

  // Scoreboard monitor: measure each phi2 cycle and compare against the queue.
  always @(negedge fpga_clk) begin
    if (rst_n) check_output("start_pulse", cycle_start, (phi2 && !prev_phi2));
    if (phi2 && !in_cycle) begin
      in_cycle = 1'b1;
      width    = 1;
      got_addr = address;
      got_rw   = rwbar;
    end else if (phi2) begin
      width++;
    end else if (in_cycle) begin
      in_cycle = 1'b0;
      check_output("sb_pending", (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        txn_t t;
        t = exp_q.pop_front();
        check_output("sb_addr", got_addr, t.addr);
        check_output("sb_rw", got_rw, t.rw);
        check_output("sb_width", width, t.width);
      end
    end
    prev_phi2 = phi2;
  end

  initial begin
    int   err_pulses;
    txn_t t;

    $display("[TB] reset");
    rst_n = 1'b0;
    repeat (3) step();
    check_output("rst_phi2", phi2, 0);
    check_output("rst_rwbar", rwbar, 1);
    check_output("rst_address", address, 0);
    check_output("rst_start", cycle_start, 0);
    check_output("rst_err", protocol_err, 0);
    rst_n = 1'b1;
    repeat (2) step();

    $display("[TB] read and write cycles");
    run_cycle(16'hC123, 1'b1, 10);
    run_cycle(16'h2000, 1'b0, 8);

    $display("[TB] one-clock glitch");
    apply_stimulus(16'h5555, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    bus_idle();
    for (int k = 0; k < 6; k++) begin
      step();
      check_output("glitch_phi2", phi2, 0);
      check_output("glitch_addr", address, 16'h2000);
    end

    $display("[TB] refresh cycles");
    apply_stimulus(16'h007F, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      step();
      check_output("rfsh_phi2", phi2, 0);
    end
    apply_stimulus(16'h007E, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      step();
      check_output("rfsh_rd_phi2", phi2, 0);
    end
    bus_idle();
    z80_rfsh_n = 1'b1;
    repeat (3) step();
    run_cycle(16'h4A5C, 1'b1, 6);

    $display("[TB] RD_n and WR_n both low");
    err_pulses = 0;
    apply_stimulus(16'h1111, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      if (k == 5) bus_idle();
      step();
      check_output("both_phi2", phi2, 0);
      if (protocol_err === 1'b1) err_pulses++;
    end
    check_output("err_pulses", err_pulses, 1);

    $display("[TB] reset during ACTIVE");
    t.addr  = 16'h8001;
    t.rw    = 1'b1;
    t.width = 1;
    exp_q.push_back(t);
    apply_stimulus(16'h8001, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (RISE) step();
    check_output("pre_rst_phi2", phi2, 1);
    rst_n = 1'b0;
    bus_idle();
    step();
    check_output("midrst_phi2", phi2, 0);
    check_output("midrst_rwbar", rwbar, 1);
    check_output("midrst_addr", address, 0);
    step();
    rst_n = 1'b1;
    repeat (2) step();
    run_cycle(16'h1234, 1'b1, 6);

    repeat (4) step();
    check_output("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
